// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, PSR bit layout,
// FSM state type and opcode classification helpers.
package alu_issue_ctrl_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_L = 1;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_Z = 3;
  localparam int unsigned PSR_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  function automatic logic op_writes_reg(input logic [7:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_LSH, OP_ASHU: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_supported(input logic [7:0] op);
    return op_writes_reg(op) || (op == OP_CMP);
  endfunction

  // PSR bits an opcode is allowed to modify; zero for everything else.
  function automatic logic [4:0] psr_mask(input logic [7:0] op);
    logic [4:0] m;
    m = '0;
    if (op == OP_ADD) begin
      m[PSR_C] = 1'b1;
      m[PSR_F] = 1'b1;
    end else if (op == OP_CMP) begin
      m[PSR_L] = 1'b1;
      m[PSR_Z] = 1'b1;
      m[PSR_N] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Combinational 16-bit ALU. Shift amount is B[4:0] as a signed value:
// positive shifts left, negative shifts right (logical for LSH, arithmetic for ASHU).
module alu_issue_ctrl_alu
  import alu_issue_ctrl_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [7:0]  Op,
  output logic [4:0]  Flags,
  output logic [15:0] Output
);

  logic [16:0] sum;
  logic [4:0]  neg_amt;

  always_comb begin
    Output  = '0;
    Flags   = '0;
    sum     = {1'b0, A} + {1'b0, B};
    neg_amt = 5'd0 - B[4:0];
    case (Op)
      OP_AND: Output = A & B;
      OP_OR:  Output = A | B;
      OP_XOR: Output = A ^ B;
      OP_ADD: begin
        Output       = sum[15:0];
        Flags[PSR_C] = sum[16];
        Flags[PSR_F] = (A[15] == B[15]) && (sum[15] != A[15]);
      end
      OP_CMP: begin
        Flags[PSR_L] = A < B;
        Flags[PSR_Z] = A == B;
        Flags[PSR_N] = $signed(A) < $signed(B);
      end
      OP_LSH:  Output = B[4] ? (A >> neg_amt) : (A << B[3:0]);
      OP_ASHU: Output = B[4] ? 16'($signed(A) >>> neg_amt) : (A << B[3:0]);
      default: begin
        Output = '0;
        Flags  = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-cycle ALU command issue controller: operand capture, execute, writeback,
// with an inline register file, preload port and masked PSR update.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [3:0]  cmd_rdest,
  input  logic [3:0]  cmd_rsrc,
  input  logic        cmd_imm_en,
  input  logic [15:0] cmd_imm,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [4:0]  psr,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  op_q, op_d;
  logic [3:0]  rdest_q, rdest_d;
  logic [15:0] res_q, res_d;
  logic [4:0]  flags_q, flags_d;
  logic [4:0]  psr_q, psr_d;
  logic [15:0] regs_q [NREGS];
  logic [15:0] regs_d [NREGS];

  logic [4:0]  alu_flags;
  logic [15:0] alu_out;

  // Loop-based lookup keeps addresses >= NREGS reading as zero for any NREGS.
  function automatic logic [15:0] rd_reg(input logic [3:0] addr);
    logic [15:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (32'(addr) == i) v = regs_q[i];
    end
    return v;
  endfunction

  alu_issue_ctrl_alu u_alu (
    .A      (a_q),
    .B      (b_q),
    .Op     (op_q),
    .Flags  (alu_flags),
    .Output (alu_out)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rdest_d   = rdest_q;
    res_d     = res_q;
    flags_d   = flags_q;
    psr_d     = psr_q;
    regs_d    = regs_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (ld_en) begin
          for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(ld_addr) == i) regs_d[i] = ld_data;
          end
        end
        // Operands come from regs_q, so a same-edge load is not seen here.
        if (cmd_valid) begin
          a_d     = rd_reg(cmd_rdest);
          b_d     = cmd_imm_en ? cmd_imm : rd_reg(cmd_rsrc);
          op_d    = cmd_op;
          rdest_d = cmd_rdest;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_out;
        flags_d = alu_flags;
        state_d = ST_WB;
      end
      ST_WB: begin
        done = 1'b1;
        err  = !op_supported(op_q);
        if (op_writes_reg(op_q)) begin
          for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(rdest_q) == i) regs_d[i] = res_q;
          end
        end
        psr_d   = (psr_q & ~psr_mask(op_q)) | (flags_q & psr_mask(op_q));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rdest_q <= '0;
      res_q   <= '0;
      flags_q <= '0;
      psr_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rdest_q <= rdest_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      psr_q   <= psr_d;
      regs_q  <= regs_d;
    end
  end

  assign dbg_data = rd_reg(dbg_addr);
  assign psr      = psr_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed table-driven bench for alu_issue_ctrl plus hand-written sequences
// for same-edge load, load during execution and reset abort.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [3:0]  cmd_rdest;
  logic [3:0]  cmd_rsrc;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [4:0]  psr;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  alu_issue_ctrl #(.NREGS(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rdest (cmd_rdest),
    .cmd_rsrc  (cmd_rsrc),
    .cmd_imm_en(cmd_imm_en),
    .cmd_imm   (cmd_imm),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .psr       (psr),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nld;
    logic [3:0]  la0;
    logic [15:0] ld0;
    logic [3:0]  la1;
    logic [15:0] ld1;
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        ie;
    logic [15:0] imm;
    logic        hold;
    logic [15:0] exp_r;
    logic [4:0]  exp_psr;
    logic        exp_err;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] addr, output logic [15:0] val);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic drive_cmd(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic ie, input logic [15:0] imm);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_rdest  = rd;
    cmd_rsrc   = rs;
    cmd_imm_en = ie;
    cmd_imm    = imm;
  endtask

  // Handshake in the current cycle, then follow the command through WB and T2.
  task automatic run_cmd(input string tag, input logic hold, input logic exp_err);
    int k;
    check({tag, "_ready_idle"}, 16'(cmd_ready), 16'd1);
    tick();
    k = 1;
    if (!hold) cmd_valid = 1'b0;
    check({tag, "_ready_exec"}, 16'(cmd_ready), 16'd0);
    while (!done && k < 6) begin
      tick();
      k++;
    end
    check({tag, "_done_lat"}, 16'(k), 16'd2);
    check({tag, "_err"}, 16'(err), 16'(exp_err));
    check({tag, "_ready_wb"}, 16'(cmd_ready), 16'd0);
    tick();
    check({tag, "_done_clr"}, 16'(done), 16'd0);
  endtask

  initial begin
    logic [15:0] v;
    string tag;

    vt[0]  = '{2, 4'd1,  16'hFFFF, 4'd2,  16'h0064, 8'h05, 4'd1,  4'd2,  1'b0, 16'h0000, 1'b0, 16'h0063, 5'h01, 1'b0};
    vt[1]  = '{1, 4'd3,  16'h0028, 4'd0,  16'h0000, 8'h03, 4'd3,  4'd0,  1'b1, 16'h0064, 1'b0, 16'h004C, 5'h01, 1'b0};
    vt[2]  = '{2, 4'd4,  16'h0003, 4'd5,  16'h0003, 8'h0B, 4'd4,  4'd5,  1'b0, 16'h0000, 1'b0, 16'h0003, 5'h09, 1'b0};
    vt[3]  = '{1, 4'd6,  16'h1021, 4'd0,  16'h0000, 8'h84, 4'd6,  4'd0,  1'b1, 16'h0008, 1'b1, 16'h2100, 5'h09, 1'b0};
    vt[4]  = '{1, 4'd7,  16'h00F0, 4'd0,  16'h0000, 8'h01, 4'd7,  4'd0,  1'b1, 16'h0F3C, 1'b0, 16'h0030, 5'h09, 1'b0};
    vt[5]  = '{2, 4'd8,  16'h1200, 4'd9,  16'h0034, 8'h02, 4'd8,  4'd9,  1'b0, 16'h0000, 1'b0, 16'h1234, 5'h09, 1'b0};
    vt[6]  = '{1, 4'd10, 16'h8000, 4'd0,  16'h0000, 8'h86, 4'd10, 4'd0,  1'b1, 16'hFFFC, 1'b0, 16'hF800, 5'h09, 1'b0};
    vt[7]  = '{2, 4'd11, 16'h7FFF, 4'd12, 16'h0001, 8'h05, 4'd11, 4'd12, 1'b0, 16'h0000, 1'b0, 16'h8000, 5'h0C, 1'b0};
    vt[8]  = '{0, 4'd0,  16'h0000, 4'd0,  16'h0000, 8'h0B, 4'd11, 4'd12, 1'b0, 16'h0000, 1'b0, 16'h8000, 5'h14, 1'b0};
    vt[9]  = '{0, 4'd0,  16'h0000, 4'd0,  16'h0000, 8'hFF, 4'd12, 4'd0,  1'b0, 16'h0000, 1'b0, 16'h0001, 5'h14, 1'b1};
    vt[10] = '{1, 4'd13, 16'h8001, 4'd0,  16'h0000, 8'h84, 4'd13, 4'd0,  1'b1, 16'h001F, 1'b0, 16'h4000, 5'h14, 1'b0};
    vt[11] = '{1, 4'd14, 16'h0001, 4'd0,  16'h0000, 8'h05, 4'd14, 4'd0,  1'b1, 16'hFFFF, 1'b0, 16'h0000, 5'h11, 1'b0};

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rdest = '0; cmd_rsrc = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    tick();
    tick();
    check("rst_ready", 16'(cmd_ready), 16'd1);
    check("rst_done", 16'(done), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_psr", 16'(psr), 16'h0000);
    reset_n = 1'b1;
    tick();
    peek(4'd0, v);
    check("rst_r0", v, 16'h0000);
    peek(4'd15, v);
    check("rst_r15", v, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      tag = $sformatf("v%0d", i);
      if (vt[i].nld > 0) load(vt[i].la0, vt[i].ld0);
      if (vt[i].nld > 1) load(vt[i].la1, vt[i].ld1);
      drive_cmd(vt[i].op, vt[i].rd, vt[i].rs, vt[i].ie, vt[i].imm);
      run_cmd(tag, vt[i].hold, vt[i].exp_err);
      peek(vt[i].rd, v);
      check({tag, "_reg"}, v, vt[i].exp_r);
      check({tag, "_psr"}, 16'(psr), 16'(vt[i].exp_psr));
      if (vt[i].hold) begin
        cmd_valid = 1'b0;
        tick();
        peek(vt[i].rd, v);
        check({tag, "_single_exec"}, v, vt[i].exp_r);
      end
    end

    // Loads offered during EXEC and WB must be dropped.
    drive_cmd(8'h02, 4'd15, 4'd0, 1'b1, 16'h0001);
    tick();
    cmd_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 4'd15; ld_data = 16'hAAAA;
    tick();
    check("ldbusy_done", 16'(done), 16'd1);
    tick();
    ld_en = 1'b0;
    peek(4'd15, v);
    check("ldbusy_r15", v, 16'h0001);
    check("ldbusy_psr", 16'(psr), 16'h0011);

    // Load and handshake on the same edge: command sees the pre-load R1 (0x0063).
    drive_cmd(8'h05, 4'd1, 4'd0, 1'b1, 16'h0001);
    ld_en = 1'b1; ld_addr = 4'd1; ld_data = 16'h1000;
    tick();
    ld_en = 1'b0;
    cmd_valid = 1'b0;
    peek(4'd1, v);
    check("samedge_load", v, 16'h1000);
    tick();
    check("samedge_done", 16'(done), 16'd1);
    tick();
    peek(4'd1, v);
    check("samedge_wb", v, 16'h0064);
    check("samedge_psr", 16'(psr), 16'h0010);

    // Reset asserted while the command is in EXEC.
    drive_cmd(8'h05, 4'd2, 4'd0, 1'b1, 16'h0001);
    tick();
    cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_ready_in_rst", 16'(cmd_ready), 16'd1);
    check("abort_psr_in_rst", 16'(psr), 16'h0000);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("abort_no_done%0d", c), 16'(done), 16'd0);
    end
    peek(4'd1, v);
    check("abort_r1", v, 16'h0000);
    peek(4'd2, v);
    check("abort_r2", v, 16'h0000);
    check("abort_psr", 16'(psr), 16'h0000);
    check("abort_ready", 16'(cmd_ready), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
